brc_seq: RTL and testbench

Parametrised, multi-cycle successor to the single-cycle branch comparator. It compares two DATA_W-bit operands MSB-first, CHUNK_W bits per cycle, and stops early at the first differing chunk. It resolves the branch condition from the RV32 branch funct3 and returns the result over a valid/ready handshake. It sits in the execute path of multi-cycle and pipelined core variants, where a full-width single-cycle compare would limit clock frequency.

---
 rtl/brc_pkg.sv | 43 ++++
 rtl/brc_chunk_cmp.sv | 15 +
 rtl/brc_seq.sv | 120 ++++++++++++
 tb/tb_brc_seq.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/brc_pkg.sv
// Shared types and helpers for the sequential branch comparator.
// Holds the FSM state encoding and RV32 branch funct3 codes.
package brc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      DONE = 2'd2
   } brc_state_e;

   localparam logic [2:0] BR_BEQ  = 3'b000;
   localparam logic [2:0] BR_BNE  = 3'b001;
   localparam logic [2:0] BR_BLT  = 3'b100;
   localparam logic [2:0] BR_BGE  = 3'b101;
   localparam logic [2:0] BR_BLTU = 3'b110;
   localparam logic [2:0] BR_BGEU = 3'b111;

   // funct3 010/011 have no branch meaning
   function automatic logic br_illegal(input logic [2:0] op);
      return (op[2:1] == 2'b01);
   endfunction

   // Branch condition from the final less/equal flags
   function automatic logic br_taken(
      input logic [2:0] op,
      input logic       less,
      input logic       equal
   );
      logic t;
      t = 1'b0;
      case (op)
         BR_BEQ:  t = equal;
         BR_BNE:  t = ~equal;
         BR_BLT:  t = less;
         BR_BGE:  t = ~less;
         BR_BLTU: t = less;
         BR_BGEU: t = ~less;
         default: t = 1'b0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/brc_chunk_cmp.sv
// Combinational unsigned compare of one operand chunk.
// Reused every cycle on the slice selected by the chunk index.
module brc_chunk_cmp #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         less,
   output logic         equal
);

   assign less  = (a < b);
   assign equal = (a == b);

endmodule

// File: rtl/brc_seq.sv
// Multi-cycle MSB-first branch comparator with early exit.
// Signed compares become unsigned by flipping both sign bits.
module brc_seq
   import brc_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int CHUNK_W = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_rs1_data,
   input  logic [DATA_W-1:0] i_rs2_data,
   input  logic [2:0]        i_br_op,
   input  logic              i_flush,
   output logic              o_valid,
   input  logic              i_ready,
   output logic              o_br_less,
   output logic              o_br_equal,
   output logic              o_br_taken,
   output logic              o_illegal
);

   localparam int NCHUNK = (CHUNK_W >= 1) ? DATA_W / CHUNK_W : 1;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   if (CHUNK_W < 1 || CHUNK_W > DATA_W || (DATA_W % CHUNK_W) != 0) begin : g_bad_param
      $fatal(1, "brc_seq: DATA_W must be a multiple of CHUNK_W, 1 <= CHUNK_W <= DATA_W");
   end

   brc_state_e        state_q;
   brc_state_e        state_d;
   logic [IDXW-1:0]   idx_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [2:0]        op_q;
   logic [DATA_W-1:0] flip;
   logic [CHUNK_W-1:0] a_chunk;
   logic [CHUNK_W-1:0] b_chunk;
   logic              c_less;
   logic              c_equal;
   logic              accept;
   logic              last;
   logic              finish;

   assign flip    = i_br_op[1] ? '0 : (DATA_W'(1) << (DATA_W - 1));
   assign a_chunk = a_q[idx_q*CHUNK_W +: CHUNK_W];
   assign b_chunk = b_q[idx_q*CHUNK_W +: CHUNK_W];

   brc_chunk_cmp #(
      .W (CHUNK_W)
   ) u_cmp (
      .a     (a_chunk),
      .b     (b_chunk),
      .less  (c_less),
      .equal (c_equal)
   );

   assign accept = (state_q == IDLE) & i_valid & ~i_flush;
   assign last   = ~c_equal | (idx_q == '0);
   assign finish = (state_q == CMP) & ~i_flush & last;

   assign o_ready = (state_q == IDLE);
   assign o_valid = (state_q == DONE);

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next-state decode; flush always wins
   always_comb begin
      state_d = state_q;
      if (i_flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (i_valid) state_d = CMP;
            CMP:     if (last)    state_d = DONE;
            DONE:    if (i_ready) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Operand capture and chunk index walk
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         a_q   <= '0;
         b_q   <= '0;
         op_q  <= '0;
         idx_q <= '0;
      end else if (accept) begin
         a_q   <= i_rs1_data ^ flip;
         b_q   <= i_rs2_data ^ flip;
         op_q  <= i_br_op;
         idx_q <= IDXW'(NCHUNK - 1);
      end else if (state_q == CMP && !i_flush && !last) begin
         idx_q <= idx_q - 1'b1;
      end
   end

   // Result registers load only on a committed CMP->DONE edge
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_br_less  <= 1'b0;
         o_br_equal <= 1'b0;
         o_br_taken <= 1'b0;
         o_illegal  <= 1'b0;
      end else if (finish) begin
         o_br_less  <= c_less;
         o_br_equal <= c_equal;
         o_br_taken <= br_taken(op_q, c_less, c_equal);
         o_illegal  <= br_illegal(op_q);
      end
   end

endmodule

// File: tb/tb_brc_seq.sv
// Directed bench for brc_seq with an expected-result queue.
// Expected flags and latency come from a behavioural model.
module tb_brc_seq;

   localparam int DW = 32;
   localparam int CW = 8;
   localparam int NC = DW / CW;

   typedef struct {
      logic less;
      logic equal;
      logic taken;
      logic illegal;
      int   lat;
   } exp_t;

   logic          i_clk = 1'b0;
   logic          i_rst_n = 1'b0;
   logic          i_valid = 1'b0;
   logic          o_ready;
   logic [DW-1:0] i_rs1_data = '0;
   logic [DW-1:0] i_rs2_data = '0;
   logic [2:0]    i_br_op = 3'b000;
   logic          i_flush = 1'b0;
   logic          o_valid;
   logic          i_ready = 1'b0;
   logic          o_br_less;
   logic          o_br_equal;
   logic          o_br_taken;
   logic          o_illegal;

   int   total = 0;
   int   bad = 0;
   exp_t sb[$];

   brc_seq #(
      .DATA_W  (DW),
      .CHUNK_W (CW)
   ) dut (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .i_rs1_data (i_rs1_data),
      .i_rs2_data (i_rs2_data),
      .i_br_op    (i_br_op),
      .i_flush    (i_flush),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_br_less  (o_br_less),
      .o_br_equal (o_br_equal),
      .o_br_taken (o_br_taken),
      .o_illegal  (o_illegal)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [DW-1:0] a,
                                  input logic [DW-1:0] b,
                                  input logic [2:0] op);
      exp_t e;
      logic [DW-1:0] x;
      bit found;
      e.equal = (a == b);
      e.less  = op[1] ? (a < b) : ($signed(a) < $signed(b));
      e.illegal = (op == 3'b010) || (op == 3'b011);
      case (op)
         3'b000:          e.taken = e.equal;
         3'b001:          e.taken = ~e.equal;
         3'b100, 3'b110:  e.taken = e.less;
         3'b101, 3'b111:  e.taken = ~e.less;
         default:         e.taken = 1'b0;
      endcase
      x = a ^ b;
      e.lat = NC;
      found = 0;
      for (int i = NC - 1; i >= 0; i--) begin
         if (!found && x[i*CW +: CW] != '0) begin
            e.lat = NC - i;
            found = 1;
         end
      end
      return e;
   endfunction

   task automatic req(input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [2:0] op, input int hold, input string tag);
      exp_t e;
      exp_t g;
      int   k;
      e = model(a, b, op);
      sb.push_back(e);
      check({tag, "_ready"}, o_ready, 1);
      i_rs1_data = a;
      i_rs2_data = b;
      i_br_op    = op;
      i_valid    = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      k = 0;
      while (!o_valid && k < 20) begin
         @(posedge i_clk); #1;
         k++;
      end
      check({tag, "_valid"}, o_valid, 1);
      check({tag, "_lat"}, k, e.lat);
      g = sb.pop_front();
      check({tag, "_less"}, o_br_less, g.less);
      check({tag, "_equal"}, o_br_equal, g.equal);
      check({tag, "_taken"}, o_br_taken, g.taken);
      check({tag, "_illegal"}, o_illegal, g.illegal);
      for (int h = 0; h < hold; h++) begin
         @(posedge i_clk); #1;
         check({tag, "_hold_valid"}, o_valid, 1);
         check({tag, "_hold_ready"}, o_ready, 0);
         check({tag, "_hold_res"},
               {o_br_less, o_br_equal, o_br_taken, o_illegal},
               {g.less, g.equal, g.taken, g.illegal});
      end
      i_ready = 1'b1;
      @(posedge i_clk); #1;
      i_ready = 1'b0;
      check({tag, "_idle_ready"}, o_ready, 1);
      check({tag, "_idle_valid"}, o_valid, 0);
   endtask

   initial begin
      logic [3:0] prev;
      #12;
      check("rst_ready", o_ready, 1);
      check("rst_valid", o_valid, 0);
      check("rst_res", {o_br_less, o_br_equal, o_br_taken, o_illegal}, 0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(posedge i_clk); #1;

      req(32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 0, "blt_top");
      req(32'h1234_5678, 32'h1234_5678, 3'b000, 0, "beq_eq");
      req(32'h8000_0000, 32'h8000_0001, 3'b111, 0, "bgeu_low");
      req(32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 0, "bltu_top");
      req(32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 0, "blt_same");
      req(32'h00AB_0000, 32'h00AC_0000, 3'b010, 5, "illegal_bp");
      req(32'h0000_7F00, 32'h0000_8000, 3'b101, 0, "bge_mid");
      req(32'h5555_0001, 32'h5555_0001, 3'b001, 0, "bne_eq");
      for (int r = 0; r < 6; r++) begin
         logic [31:0] ra;
         logic [31:0] rb;
         logic [2:0]  ro;
         ra = $urandom;
         rb = (r % 2 == 0) ? ra ^ (32'h1 << $urandom_range(31, 0)) : $urandom;
         ro = 3'($urandom_range(7, 0));
         req(ra, rb, ro, r % 3, "rand");
      end

      // Leave a known result behind, then flush in the 2nd CMP cycle
      req(32'hCAFE_0000, 32'hCAFE_0000, 3'b000, 0, "pre_flush");
      prev = {o_br_less, o_br_equal, o_br_taken, o_illegal};
      i_rs1_data = 32'h0000_0001;
      i_rs2_data = 32'h0000_0001;
      i_br_op    = 3'b001;
      i_valid    = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      @(posedge i_clk); #1;
      i_flush = 1'b1;
      i_valid = 1'b1;
      @(posedge i_clk); #1;
      i_flush = 1'b0;
      i_valid = 1'b0;
      check("flush_ready", o_ready, 1);
      check("flush_valid", o_valid, 0);
      for (int w = 0; w < 6; w++) begin
         @(posedge i_clk); #1;
         check("flush_no_valid", o_valid, 0);
         check("flush_res", {o_br_less, o_br_equal, o_br_taken, o_illegal}, prev);
      end

      // Reset pulse mid-CMP
      i_rs1_data = 32'h1111_1111;
      i_rs2_data = 32'h1111_1111;
      i_br_op    = 3'b000;
      i_valid    = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      @(posedge i_clk); #1;
      i_rst_n = 1'b0;
      #1;
      check("mrst_ready", o_ready, 1);
      check("mrst_valid", o_valid, 0);
      check("mrst_res", {o_br_less, o_br_equal, o_br_taken, o_illegal}, 0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      for (int w = 0; w < 5; w++) begin
         @(posedge i_clk); #1;
         check("mrst_no_valid", o_valid, 0);
      end
      req(32'h0000_0002, 32'h0000_0003, 3'b100, 0, "post_rst");

      check("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
